// File: rtl/cnn_window_addr_gen_if.sv
// Handshake/bus bundle between the window address generator and its controller/consumer.
// The master modport is the generator side; slave is the controller/MAC side.
interface cnn_window_addr_gen_if #(
  parameter int addr_width_p = 16
);
  logic                    start_i;
  logic [addr_width_p-1:0] base_i;
  logic                    ready_i;
  logic                    valid_o;
  logic [addr_width_p-1:0] addr_o;
  logic                    pad_o;
  logic                    last_o;
  logic                    done_o;
  logic                    busy_o;

  modport master (
    input  start_i, base_i, ready_i,
    output valid_o, addr_o, pad_o, last_o, done_o, busy_o
  );

  modport slave (
    output start_i, base_i, ready_i,
    input  valid_o, addr_o, pad_o, last_o, done_o, busy_o
  );
endinterface

// File: rtl/cnn_window_addr_gen.sv
// Sliding-window feature-map address generator: walks (out row, out col, k row, k col).
// Optional "same" zero padding is enabled with macro CNN_WINDOW_ADDR_GEN_PAD_EN.
module cnn_window_addr_gen #(
  parameter int in_w_p       = 4,
  parameter int in_h_p       = 4,
  parameter int k_p          = 3,
  parameter int stride_p     = 1,
  parameter int addr_width_p = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  cnn_window_addr_gen_if.master bus
);

  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

`ifdef CNN_WINDOW_ADDR_GEN_PAD_EN
  localparam int PAD = (k_p - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT_W = (in_w_p + 2 * PAD - k_p) / stride_p + 1;
  localparam int OUT_H = (in_h_p + 2 * PAD - k_p) / stride_p + 1;
  localparam int KW    = cw(k_p);
  localparam int OCW   = cw(OUT_W);
  localparam int ORW   = cw(OUT_H);
  localparam int AW    = addr_width_p + 2;

  localparam logic [KW-1:0]  K_MAX  = KW'(k_p - 1);
  localparam logic [OCW-1:0] OC_MAX = OCW'(OUT_W - 1);
  localparam logic [ORW-1:0] OR_MAX = ORW'(OUT_H - 1);

  localparam logic signed [AW-1:0] STRIDE_S = AW'(stride_p);
  localparam logic signed [AW-1:0] PAD_S    = AW'(PAD);
  localparam logic signed [AW-1:0] INW_S    = AW'(in_w_p);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [KW-1:0]           kc_reg, kc_next, kr_reg, kr_next;
  logic [OCW-1:0]          ocol_reg, ocol_next;
  logic [ORW-1:0]          orow_reg, orow_next;
  logic [addr_width_p-1:0] base_reg, base_next;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      kc_reg    <= '0;
      kr_reg    <= '0;
      ocol_reg  <= '0;
      orow_reg  <= '0;
      base_reg  <= '0;
    end else begin
      state_reg <= state_next;
      kc_reg    <= kc_next;
      kr_reg    <= kr_next;
      ocol_reg  <= ocol_next;
      orow_reg  <= orow_next;
      base_reg  <= base_next;
    end
  end

  // Chained counters: kc innermost; the wrap of the outermost ends the frame.
  always_comb begin
    state_next = state_reg;
    kc_next    = kc_reg;
    kr_next    = kr_reg;
    ocol_next  = ocol_reg;
    orow_next  = orow_reg;
    base_next  = base_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start_i) begin
          base_next  = bus.base_i;
          kc_next    = '0;
          kr_next    = '0;
          ocol_next  = '0;
          orow_next  = '0;
          state_next = RUN;
        end
      end
      RUN: begin
        if (bus.ready_i) begin
          if (kc_reg == K_MAX) begin
            kc_next = '0;
            if (kr_reg == K_MAX) begin
              kr_next = '0;
              if (ocol_reg == OC_MAX) begin
                ocol_next = '0;
                if (orow_reg == OR_MAX) begin
                  orow_next  = '0;
                  state_next = DONE;
                end else begin
                  orow_next = orow_reg + 1'b1;
                end
              end else begin
                ocol_next = ocol_reg + 1'b1;
              end
            end else begin
              kr_next = kr_reg + 1'b1;
            end
          end else begin
            kc_next = kc_reg + 1'b1;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  logic                    valid;
  logic signed [AW-1:0]    row_s, col_s;
  logic [addr_width_p-1:0] addr_calc;

  assign valid = (state_reg == RUN);

  always_comb begin
    row_s     = signed'(AW'(orow_reg)) * STRIDE_S + signed'(AW'(kr_reg)) - PAD_S;
    col_s     = signed'(AW'(ocol_reg)) * STRIDE_S + signed'(AW'(kc_reg)) - PAD_S;
    addr_calc = addr_width_p'(signed'(AW'(base_reg)) + row_s * INW_S + col_s);
  end

`ifdef CNN_WINDOW_ADDR_GEN_PAD_EN
  localparam logic signed [AW-1:0] INH_S = AW'(in_h_p);
  logic oob;
  assign oob        = (row_s < 0) || (row_s >= INH_S) || (col_s < 0) || (col_s >= INW_S);
  assign bus.pad_o  = valid && oob;
  assign bus.addr_o = (valid && !oob) ? addr_calc : '0;
`else
  assign bus.pad_o  = 1'b0;
  assign bus.addr_o = valid ? addr_calc : '0;
`endif

  assign bus.valid_o = valid;
  assign bus.last_o  = valid && (kr_reg == K_MAX) && (kc_reg == K_MAX);
  assign bus.done_o  = (state_reg == DONE);
  assign bus.busy_o  = (state_reg != IDLE);

endmodule

// File: tb/tb_cnn_window_addr_gen.sv
// Directed + randomized bench for cnn_window_addr_gen; expected beats come from a loop-nest model.
// Drives two instances: defaults (4x4, k3, s1) and 5x5, k3, stride 2.
module tb_cnn_window_addr_gen;

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  cnn_window_addr_gen_if #(.addr_width_p(16)) if0 ();
  cnn_window_addr_gen_if #(.addr_width_p(16)) if1 ();

  cnn_window_addr_gen u_dut0 (.clk_i(clk_i), .reset_i(reset_i), .bus(if0));
  cnn_window_addr_gen #(.in_w_p(5), .in_h_p(5), .k_p(3), .stride_p(2), .addr_width_p(16))
    u_dut1 (.clk_i(clk_i), .reset_i(reset_i), .bus(if1));

`ifdef CNN_WINDOW_ADDR_GEN_PAD_EN
  localparam int PADV = 1;
`else
  localparam int PADV = 0;
`endif

  typedef struct {
    logic [15:0] addr;
    logic        pad;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    sel = 0;
  int    checks = 0;
  int    errors = 0;

  logic        ov, opad, olast, odone, obusy;
  logic [15:0] oaddr;
  assign ov    = (sel == 0) ? if0.valid_o : if1.valid_o;
  assign opad  = (sel == 0) ? if0.pad_o   : if1.pad_o;
  assign olast = (sel == 0) ? if0.last_o  : if1.last_o;
  assign odone = (sel == 0) ? if0.done_o  : if1.done_o;
  assign obusy = (sel == 0) ? if0.busy_o  : if1.busy_o;
  assign oaddr = (sel == 0) ? if0.addr_o  : if1.addr_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic [15:0] b, input logic r);
    if (sel == 0) begin
      if0.start_i = st; if0.base_i = b; if0.ready_i = r;
    end else begin
      if1.start_i = st; if1.base_i = b; if1.ready_i = r;
    end
  endtask

  // Reference: enumerate the window nest directly from the geometry.
  function automatic void build(input int s, input logic [15:0] base);
    int w, h, k, st, p, ow, oh, row, col;
    beat_t b;
    w = (s == 0) ? 4 : 5;
    h = w;
    k = 3;
    st = (s == 0) ? 1 : 2;
    p = PADV ? (k - 1) / 2 : 0;
    ow = (w + 2 * p - k) / st + 1;
    oh = (h + 2 * p - k) / st + 1;
    exp_q.delete();
    for (int orr = 0; orr < oh; orr++)
      for (int oc = 0; oc < ow; oc++)
        for (int kr = 0; kr < k; kr++)
          for (int kc = 0; kc < k; kc++) begin
            row = orr * st + kr - p;
            col = oc * st + kc - p;
            b.pad  = (row < 0) || (row >= h) || (col < 0) || (col >= w);
            b.addr = b.pad ? 16'h0 : 16'(int'(base) + row * w + col);
            b.last = (kr == k - 1) && (kc == k - 1);
            exp_q.push_back(b);
          end
  endfunction

  // mode 0: ready always; 1: random ready; 2: 3-cycle stall on beat 4.
  task automatic run_frame(input int s, input logic [15:0] base, input int mode, input int abort_at);
    int   idx, cyc, stall;
    logic r;
    build(s, base);
    sel = s;
    @(negedge clk_i);
    chk("idle_valid", 32'(ov), 0);
    chk("idle_busy", 32'(obusy), 0);
    set_in(1'b1, base, 1'b0);
    @(negedge clk_i);
    set_in(1'b0, 16'hdead, 1'b0);
    idx = 0; cyc = 0; stall = 0;
    while (idx < exp_q.size() && cyc < 4000) begin
      chk("valid", 32'(ov), 1);
      chk("busy", 32'(obusy), 1);
      chk("done_run", 32'(odone), 0);
      chk("addr", 32'(oaddr), 32'(exp_q[idx].addr));
      chk("pad", 32'(opad), 32'(exp_q[idx].pad));
      chk("last", 32'(olast), 32'(exp_q[idx].last));
      if (idx == abort_at) begin
        reset_i = 1'b1;
        set_in(1'b1, 16'h0, 1'b1);
        @(negedge clk_i);
        chk("abort_valid", 32'(ov), 0);
        chk("abort_done", 32'(odone), 0);
        chk("abort_busy", 32'(obusy), 0);
        reset_i = 1'b0;
        set_in(1'b0, 16'h0, 1'b0);
        @(negedge clk_i);
        chk("abort_done2", 32'(odone), 0);
        chk("abort_valid2", 32'(ov), 0);
        $display("abort sel=%0d at beat %0d", s, idx);
        return;
      end
      case (mode)
        1:       r = ($urandom_range(0, 3) != 0);
        2:       if (idx == 4 && stall < 3) begin r = 1'b0; stall++; end else r = 1'b1;
        default: r = 1'b1;
      endcase
      set_in(1'b0, 16'h0, r);
      if (r) begin
        $display("beat sel=%0d idx=%0d addr=%h pad=%0b last=%0b", s, idx, oaddr, opad, olast);
        idx++;
      end
      cyc++;
      @(negedge clk_i);
    end
    if (cyc >= 4000) begin
      checks++;
      errors++;
      $error("FAIL timeout observed=%0d beats expected=%0d", idx, exp_q.size());
    end
    chk("done_pulse", 32'(odone), 1);
    chk("done_valid", 32'(ov), 0);
    chk("done_busy", 32'(obusy), 1);
    chk("done_last", 32'(olast), 0);
    set_in(1'b1, 16'h0, 1'b0);
    @(negedge clk_i);
    chk("post_done", 32'(odone), 0);
    chk("post_busy", 32'(obusy), 0);
    set_in(1'b0, 16'h0, 1'b0);
    @(negedge clk_i);
    chk("ignored_start_valid", 32'(ov), 0);
    chk("ignored_start_busy", 32'(obusy), 0);
    $display("frame sel=%0d base=%h beats=%0d cycles=%0d", s, base, idx, cyc);
  endtask

  initial begin
    reset_i = 1'b1;
    if0.start_i = 1'b0; if0.base_i = '0; if0.ready_i = 1'b0;
    if1.start_i = 1'b0; if1.base_i = '0; if1.ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    for (int s = 0; s < 2; s++) begin
      sel = s;
      #0;
      chk("rst_valid", 32'(ov), 0);
      chk("rst_last", 32'(olast), 0);
      chk("rst_pad", 32'(opad), 0);
      chk("rst_done", 32'(odone), 0);
      chk("rst_busy", 32'(obusy), 0);
      chk("rst_addr", 32'(oaddr), 0);
    end
    reset_i = 1'b0;

    run_frame(0, 16'h0000, 0, -1);
    run_frame(0, 16'h0100, 0, -1);
    run_frame(0, 16'h0000, 2, -1);
    run_frame(1, 16'h0000, 0, -1);
    run_frame(0, 16'hfff8, 1, -1);
    run_frame(0, 16'($urandom), 1, -1);
    run_frame(1, 16'($urandom), 1, -1);
    run_frame(0, 16'h0000, 0, 10);
    run_frame(0, 16'h0000, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
